btn_step_ctrl: RTL and testbench

Upstream control stage for the 4-LED chaser on the PYNQ board. Conditions the four board push-buttons (synchronise, debounce, press-detect) and turns them into run/pause, direction and speed settings. Generates the one-cycle `step` pulse that advances the chaser, replacing the chaser's fixed 50 M-cycle divider. Drives `dir` so the chaser can rotate either way.

---
 rtl/btn_step_ctrl_if.sv | 33 +++
 rtl/btn_step_ctrl.sv | 155 +++++++++++++++
 tb/tb_btn_step_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/btn_step_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : btn_step_ctrl_if
// Description : Button inputs and chaser control outputs of btn_step_ctrl.
//               The controller side (master) drives step/run/dir/speed and
//               samples the buttons; the board/chaser side (slave) is the
//               mirror image.
// Revision    : 1.0  initial release
// ============================================================================
interface btn_step_ctrl_if;
  logic [3:0] btn;
  logic       step;
  logic       run;
  logic       dir;
  logic [1:0] speed;

  modport master (
    input  btn,
    output step,
    output run,
    output dir,
    output speed
  );

  modport slave (
    output btn,
    input  step,
    input  run,
    input  dir,
    input  speed
  );
endinterface
`default_nettype wire

// File: rtl/btn_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : btn_step_ctrl
// Description : Push-button conditioning (sync, debounce, press detect) for
//               the 4-LED chaser, plus run/direction/speed control and the
//               one-cycle step pulse generator.
// Revision    : 1.0  initial release
// ============================================================================
module btn_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int STEP_BASE       = 50_000_000,
  parameter int CNT_W           = 26
) (
  input  logic              clk,
  input  logic              rst,
  btn_step_ctrl_if.master   bus
);

  localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       s1;
  logic [3:0]       s2;
  logic [3:0]       stable;
  logic [3:0]       stable_d;
  logic [3:0]       press;

  logic             run_q;
  logic             dir_q;
  logic [1:0]       speed_q;
  logic             step_q;
  logic [CNT_W-1:0] cnt;

  logic             run_nxt;
  logic             dir_nxt;
  logic [1:0]       speed_nxt;
  logic             speed_chg;
  logic [CNT_W-1:0] term;

  // Two-flop synchroniser for the asynchronous button inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= bus.btn;
      s2 <= s1;
    end
  end

  // Per-button debounce: a new level must persist for DEBOUNCE_CYCLES cycles;
  // any return to the accepted level restarts the qualification.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_btn
      logic [DB_W-1:0] db_cnt;
      logic            stable_bit;

      // Qualification counter and accepted level for this button
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          db_cnt     <= '0;
          stable_bit <= 1'b0;
        end else if (s2[gi] == stable_bit) begin
          db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
          stable_bit <= s2[gi];
          db_cnt     <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end

      assign stable[gi] = stable_bit;
    end
  endgenerate

  // Single-cycle press on each accepted rising level; releases are ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_d <= '0;
      press    <= '0;
    end else begin
      stable_d <= stable;
      press    <= stable & ~stable_d;
    end
  end

  // Next control settings; simultaneous up/down cancel, otherwise saturate
  always_comb begin
    run_nxt   = run_q ^ press[0];
    dir_nxt   = dir_q ^ press[1];
    speed_nxt = speed_q;
    if (press[2] && !press[3] && (speed_q != 2'd3)) begin
      speed_nxt = speed_q + 2'd1;
    end else if (press[3] && !press[2] && (speed_q != 2'd0)) begin
      speed_nxt = speed_q - 2'd1;
    end
    speed_chg = (speed_nxt != speed_q);
  end

  // Terminal count of the step counter for the current speed
  always_comb begin
    term = CNT_W'(STEP_BASE - 1);
    case (speed_q)
      2'd1:    term = CNT_W'((STEP_BASE >> 1) - 1);
      2'd2:    term = CNT_W'((STEP_BASE >> 2) - 1);
      2'd3:    term = CNT_W'((STEP_BASE >> 3) - 1);
      default: term = CNT_W'(STEP_BASE - 1);
    endcase
  end

  // Control register update on press cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q   <= 1'b1;
      dir_q   <= 1'b0;
      speed_q <= 2'd0;
    end else begin
      run_q   <= run_nxt;
      dir_q   <= dir_nxt;
      speed_q <= speed_nxt;
    end
  end

  // Step generator; a speed change restarts the period so the counter never
  // overshoots a smaller terminal count. Uses pre-update run so a pause
  // landing on the terminal count still emits that pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      step_q <= 1'b0;
    end else if (speed_chg) begin
      cnt    <= '0;
      step_q <= 1'b0;
    end else if (run_q) begin
      if (cnt == term) begin
        cnt    <= '0;
        step_q <= 1'b1;
      end else begin
        cnt    <= cnt + CNT_W'(1);
        step_q <= 1'b0;
      end
    end else begin
      step_q <= 1'b0;
    end
  end

  assign bus.step  = step_q;
  assign bus.run   = run_q;
  assign bus.dir   = dir_q;
  assign bus.speed = speed_q;

endmodule
`default_nettype wire

// File: tb/tb_btn_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_btn_step_ctrl
// Description : Self-checking bench for btn_step_ctrl with directed button
//               stimulus, a behavioural model compared every cycle, and
//               hand-computed literal expectations.
// Revision    : 1.0  initial release
// ============================================================================
module tb_btn_step_ctrl;

  localparam int D  = 4;
  localparam int SB = 16;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  btn_step_ctrl_if bus();

  btn_step_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .STEP_BASE(SB),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: actual %0d required %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic       m_step;
  logic       m_run;
  logic       m_dir;
  int         m_spd;
  int         ph;          // running cycles elapsed in the current period
  logic [3:0] d1, d2;      // button value seen 1 and 2 edges ago
  logic [3:0] acc;         // accepted button levels
  logic [3:0] rp1, rp2;    // accepted rises, 1 and 2 edges old
  logic [3:0] win[$];      // last D synchronised samples

  function automatic void m_reset();
    m_step = 1'b0; m_run = 1'b1; m_dir = 1'b0; m_spd = 0; ph = 0;
    d1 = '0; d2 = '0; acc = '0; rp1 = '0; rp2 = '0;
    win.delete();
    for (int j = 0; j < D; j++) win.push_back(4'b0);
  endfunction

  function automatic void m_edge(input logic [3:0] btn_now);
    logic [3:0] newacc, app;
    int         ns;
    bit         all_diff;
    win.push_back(d2);
    void'(win.pop_front());
    newacc = acc;
    for (int i = 0; i < 4; i++) begin
      all_diff = 1'b1;
      foreach (win[j]) if (win[j][i] == acc[i]) all_diff = 1'b0;
      if (all_diff) newacc[i] = ~acc[i];
    end
    app = rp2;
    rp2 = rp1;
    rp1 = newacc & ~acc;
    acc = newacc;
    d2  = d1;
    d1  = btn_now;
    ns = m_spd + (app[2] ? 1 : 0) - (app[3] ? 1 : 0);
    if (ns > 3) ns = 3;
    if (ns < 0) ns = 0;
    if (ns != m_spd) begin
      ph = 0; m_step = 1'b0;
    end else if (m_run) begin
      ph++;
      if (ph == (SB >> m_spd)) begin m_step = 1'b1; ph = 0; end
      else m_step = 1'b0;
    end else begin
      m_step = 1'b0;
    end
    m_run = m_run ^ app[0];
    m_dir = m_dir ^ app[1];
    m_spd = ns;
  endfunction

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else     m_edge(bus.btn);
    end
  end

  // Every-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      chk("cycle_outputs", int'({bus.step, bus.run, bus.dir, bus.speed}),
          int'({m_step, m_run, m_dir, 2'(m_spd)}));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_edges(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input logic [3:0] m);
    bus.btn = m;
    wait_edges(10);
    bus.btn = 4'b0;
    wait_edges(10);
  endtask

  task automatic measure_period(input int exp);
    int n;
    n = 0;
    while (bus.step !== 1'b1 && n < 64) begin @(posedge clk); #1; n++; end
    if (n >= 64) begin
      chk("period_wait_timeout", n, 0);
    end else begin
      n = 0;
      do begin @(posedge clk); #1; n++; end while (bus.step !== 1'b1 && n < 64);
      chk("period", n, exp);
    end
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int steps;
    bus.btn = 4'b0;
    rst     = 1'b1;
    wait_edges(3);
    chk("reset_step", bus.step, 0);
    chk("reset_run", bus.run, 1);
    chk("reset_dir", bus.dir, 0);
    chk("reset_speed", bus.speed, 0);
    @(negedge clk) rst = 1'b0;

    // Free running: pulses at edges 16, 32, 48
    for (int n = 1; n <= 48; n++) begin
      @(posedge clk); #1;
      chk("step_free", bus.step, (n % 16 == 0) ? 1 : 0);
    end
    chk("free_run", bus.run, 1);

    // Clean direction press: dir flips 8 edges after the press
    bus.btn[1] = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      if (n == 7) chk("dir_before", bus.dir, 0);
      if (n == 8) chk("dir_after", bus.dir, 1);
    end
    wait_edges(12);
    bus.btn[1] = 1'b0;
    wait_edges(12);
    bus.btn[1] = 1'b1;
    wait_edges(8);
    chk("dir_second", bus.dir, 0);
    wait_edges(12);
    bus.btn[1] = 1'b0;
    wait_edges(12);

    // Bouncing run/pause button
    bus.btn[0] = 1'b1; wait_edges(1);
    bus.btn[0] = 1'b0; wait_edges(1);
    bus.btn[0] = 1'b1; wait_edges(1);
    bus.btn[0] = 1'b0; wait_edges(1);
    bus.btn[0] = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      if (n == 7) chk("run_before", bus.run, 1);
      if (n == 8) chk("run_paused", bus.run, 0);
    end
    steps = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (bus.step) steps++;
    end
    chk("paused_steps", steps, 0);
    chk("still_paused", bus.run, 0);
    bus.btn[0] = 1'b0;
    wait_edges(12);
    push(4'b0001);
    chk("run_resumed", bus.run, 1);

    // Speed up four times: 1, 2, 3, 3
    push(4'b0100); chk("speed1", bus.speed, 1); measure_period(8);
    push(4'b0100); chk("speed2", bus.speed, 2); measure_period(4);
    push(4'b0100); chk("speed3", bus.speed, 3); measure_period(2);
    push(4'b0100); chk("speed3_sat", bus.speed, 3);

    // Down to 1, then simultaneous up/down, then floor at 0
    push(4'b1000);
    push(4'b1000);
    chk("speed_down1", bus.speed, 1);
    push(4'b1100);
    chk("speed_both", bus.speed, 1);
    measure_period(8);
    push(4'b1000);
    chk("speed_down0", bus.speed, 0);
    push(4'b1000);
    chk("speed_floor", bus.speed, 0);

    // Set speed 2, dir 1, run 0, then reset mid-period
    push(4'b0100);
    push(4'b0100);
    push(4'b0010);
    push(4'b0001);
    chk("pre_rst_speed", bus.speed, 2);
    chk("pre_rst_dir", bus.dir, 1);
    chk("pre_rst_run", bus.run, 0);
    wait_edges(3);
    bus.btn[1] = 1'b1;
    #3 rst = 1'b1;
    #1;
    chk("async_rst_step", bus.step, 0);
    chk("async_rst_run", bus.run, 1);
    chk("async_rst_dir", bus.dir, 0);
    chk("async_rst_speed", bus.speed, 0);
    wait_edges(2);
    @(negedge clk) rst = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      @(posedge clk); #1;
      chk("post_rst_step", bus.step, (n == 16) ? 1 : 0);
      if (n == 7) chk("held_btn_dir_before", bus.dir, 0);
      if (n == 8) chk("held_btn_dir_after", bus.dir, 1);
    end
    bus.btn = 4'b0;
    wait_edges(12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
